// File: rtl/rc4_decrypt_fsm.sv
// RC4 PRGA / decrypt loop: walks the permuted S array, swaps S[i]/S[j] per
// byte, XORs the keystream byte with the ciphertext ROM byte and writes the
// plaintext RAM. Every output is a register loaded from the next state and
// next datapath values, so outputs follow the state with no input-to-output
// combinational path.
// Optional feature macro: RC4_DECRYPT_VALID_CHECK_EN (early abort on a
// plaintext byte that is neither space nor lower-case ASCII).
module rc4_decrypt_fsm #(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_wren,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic [ADDR_W-1:0] dout_addr,
  output logic [DATA_W-1:0] dout_wdata,
  output logic              dout_wren,
  output logic              key_valid
);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, INC, RD_I, WT_I, CAP_I, RD_J, WT_J, CAP_J,
    WR_I, WR_J, RD_F, WT_F, CAP_F, WR_OUT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DATA_W-1:0]   si_q, si_d, sj_q, sj_d, f_q, f_d, enc_q, enc_d;

  logic                busy_d, done_d, s_wren_d, dout_wren_d;
  logic [ADDR_W-1:0]   s_addr_d, rom_addr_d, dout_addr_d;
  logic [DATA_W-1:0]   s_wdata_d, dout_wdata_d;

`ifdef RC4_DECRYPT_VALID_CHECK_EN
  logic                key_valid_d;
  logic [DATA_W-1:0]   plain;
  logic                plain_ok;
`endif

  // Next state, datapath updates, and output values decoded from the next state
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    f_d     = f_q;
    enc_d   = enc_q;
`ifdef RC4_DECRYPT_VALID_CHECK_EN
    key_valid_d = key_valid;
    plain       = f_q ^ enc_q;
    plain_ok    = (plain == DATA_W'(8'h20)) ||
                  ((plain >= DATA_W'(8'h61)) && (plain <= DATA_W'(8'h7A)));
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = INC;
`ifdef RC4_DECRYPT_VALID_CHECK_EN
          key_valid_d = 1'b1;
`endif
        end
      end
      INC: begin
        i_d     = i_q + ADDR_W'(1);
        state_d = RD_I;
      end
      RD_I:  state_d = WT_I;
      WT_I:  state_d = CAP_I;
      CAP_I: begin
        si_d    = s_rdata;
        j_d     = j_q + ADDR_W'(s_rdata);
        state_d = RD_J;
      end
      RD_J:  state_d = WT_J;
      WT_J:  state_d = CAP_J;
      CAP_J: begin
        sj_d    = s_rdata;
        state_d = WR_I;
      end
      WR_I:  state_d = WR_J;
      WR_J:  state_d = RD_F;
      RD_F:  state_d = WT_F;
      WT_F:  state_d = CAP_F;
      CAP_F: begin
        f_d     = s_rdata;
        enc_d   = rom_rdata;
        state_d = WR_OUT;
      end
      WR_OUT: begin
        k_d     = k_q + ADDR_W'(1);
        state_d = (k_q == LAST_K) ? DONE : INC;
`ifdef RC4_DECRYPT_VALID_CHECK_EN
        if (!plain_ok) begin
          key_valid_d = 1'b0;
          state_d     = DONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE) && (state_d != DONE);
    done_d       = (state_d == DONE);
    s_addr_d     = '0;
    s_wdata_d    = '0;
    s_wren_d     = 1'b0;
    rom_addr_d   = '0;
    dout_addr_d  = '0;
    dout_wdata_d = '0;
    dout_wren_d  = 1'b0;

    case (state_d)
      RD_I, WT_I: s_addr_d = i_d;
      RD_J, WT_J: s_addr_d = j_d;
      WR_I: begin
        s_addr_d  = i_d;
        s_wdata_d = sj_d;
        s_wren_d  = 1'b1;
      end
      WR_J: begin
        s_addr_d  = j_d;
        s_wdata_d = si_d;
        s_wren_d  = 1'b1;
      end
      RD_F, WT_F: begin
        s_addr_d   = ADDR_W'(si_d + sj_d);
        rom_addr_d = k_d;
      end
      WR_OUT: begin
        dout_addr_d  = k_d;
        dout_wdata_d = f_d ^ enc_d;
        dout_wren_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      f_q        <= '0;
      enc_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_wren     <= 1'b0;
      rom_addr   <= '0;
      dout_addr  <= '0;
      dout_wdata <= '0;
      dout_wren  <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      f_q        <= f_d;
      enc_q      <= enc_d;
      busy       <= busy_d;
      done       <= done_d;
      s_addr     <= s_addr_d;
      s_wdata    <= s_wdata_d;
      s_wren     <= s_wren_d;
      rom_addr   <= rom_addr_d;
      dout_addr  <= dout_addr_d;
      dout_wdata <= dout_wdata_d;
      dout_wren  <= dout_wren_d;
    end
  end

`ifdef RC4_DECRYPT_VALID_CHECK_EN
  // Plaintext plausibility flag, re-armed on every start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) key_valid <= 1'b1;
    else          key_valid <= key_valid_d;
  end
`else
  assign key_valid = 1'b1;
`endif

endmodule

// File: doc/rc4_decrypt_fsm.md
Name: rc4_decrypt_fsm

Overview:
Third RC4 stage (PRGA/decrypt loop). Runs after the init and key-schedule loops have left a permuted S array in s_memory.
- Reads S through the shared S-memory port and performs the i/j swap per byte.
- Fetches ciphertext from the encrypted-message ROM.
- XORs each keystream byte with the ciphertext byte and writes plaintext to the decrypted-message RAM.
- Top level muxes the S-memory port to this block while busy=1.

Parameters:
MSG_LEN, 32, number of message bytes processed; legal range 1..256.
DATA_W, 8, width of S, ROM and output data (fixed RC4 byte).
ADDR_W, 8, S-memory and message address width.

Ports:
clk  in  1  system clock (CLK_50M at top).
reset_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse (from a trap-and-pulse synchroniser); begins decryption.
busy  out  1  high while the block owns the S-memory and output ports.
done  out  1  level; high in DONE state.
s_addr  out  ADDR_W  S-memory address.
s_wdata  out  DATA_W  S-memory write data.
s_wren  out  1  S-memory write enable.
s_rdata  in  DATA_W  S-memory read data.
rom_addr  out  ADDR_W  ciphertext ROM address.
rom_rdata  in  DATA_W  ciphertext byte.
dout_addr  out  ADDR_W  plaintext RAM address.
dout_wdata  out  DATA_W  plaintext byte.
dout_wren  out  1  plaintext RAM write enable.

Behaviour:
Interface and reset
- All outputs are Moore-decoded from the state register and datapath registers. There is no combinational path from any input to any output.
- Reset (async, reset_n=0): state=IDLE; i, j, k, si, sj, f, enc = 0; all outputs 0.
- Read timing: every memory read samples data two edges after the address is first presented. This tolerates both registered-address and registered-output altsyncram configurations.

Arithmetic
- All address arithmetic is 8-bit modulo 256: i+1, j+si, si+sj.
- k is 8 bits; with MSG_LEN=256 the terminal compare at k=255 occurs before any wrap.

States and transitions
- IDLE: if start, clear i, j, k and go to INC.
- INC: i<=i+1.
- RD_I: s_addr=i.
- WT_I: s_addr=i.
- CAP_I: si<=s_rdata; j<=j+s_rdata.
- RD_J: s_addr=j.
- WT_J: s_addr=j.
- CAP_J: sj<=s_rdata.
- WR_I: s_addr=i, s_wdata=sj, s_wren=1.
- WR_J: s_addr=j, s_wdata=si, s_wren=1.
- RD_F: s_addr=si+sj; rom_addr=k.
- WT_F: same addresses as RD_F.
- CAP_F: f<=s_rdata; enc<=rom_rdata.
- WR_OUT: dout_addr=k, dout_wdata=f^enc, dout_wren=1; k<=k+1. If k==MSG_LEN-1 go to DONE, else go to INC.
- DONE: done=1. If start, clear i, j, k and go to INC; otherwise hold.

Timing and outputs
- 13 cycles per byte. done rises on edge 13*MSG_LEN after the edge that samples start.
- busy=1 in every state except IDLE and DONE.
- i=j case (WR_I and WR_J hit the same address): both writes are performed in order. The result equals the single value, so no special handling is needed.

Boundary conditions
- start while busy: ignored.
- Reset mid-operation: returns to IDLE immediately. S and plaintext RAM are left partially updated and are not restored; loops 1/2 must be rerun before the next start.

Optional Feature:
RC4_DECRYPT_VALID_CHECK_EN
- With: adds output key_valid (1 bit, reset 1, cleared to 1 on start).
  - In WR_OUT the byte is still written.
  - If f^enc is neither 8'h20 nor in 8'h61..8'h7A, key_valid<=0 and the FSM goes to DONE regardless of k (early abort for key search).
- Without: no early abort; key_valid port exists and is tied to 1.

Test Plan:
1. Identity S (S[x]=x), ROM all 0x00, MSG_LEN=1, pulse start -> one dout write addr 0 data 0x02; done high at edge 13; S unchanged; busy high edges 1..12.
2. Identity S, ROM={0x00,0x00}, MSG_LEN=2 -> out[0]=0x02, out[1]=0x05; afterwards S[2]=0x03, S[3]=0x02, all other S[x]=x; done at edge 26.
3. Same as 2, reset_n pulsed low during byte 1 WR_I -> all outputs 0 and state IDLE immediately; out[1] never written. A later start reruns from i=j=k=0.
4. start pulsed at edge 5 of a run -> ignored; done timing identical to scenario 1.
5. VALID_CHECK_EN, identity S, ROM[0]=0x63, MSG_LEN=1 -> out[0]=0x61, key_valid=1. Same setup with ROM[0]=0x00 -> out[0]=0x02, key_valid=0.
6. VALID_CHECK_EN, identity S, ROM={0x00,...}, MSG_LEN=4 -> abort after byte 0: done at edge 13, key_valid=0, only one dout write.
